ncl4_inject_arbiter: RTL and testbench
======================================

Name: ncl4_inject_arbiter

Overview:
- Clocked front end that shares one four-rail NCL pipeline input between NREQ synchronous requesters.
- Arbitrates round-robin among requesters and converts each accepted 2-bit value into a one-hot four-rail DATA wavefront.
- Returns the pipeline to NULL between wavefronts, sequencing both phases from the first pipeline stage's completion signal.
- Sits in place of a free-running ring generator at the head of a Pipecomponent chain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- SYNC_STAGES, 2, flops in the comp_in synchronizer (>=2)
- TIMEOUT, 255, cycles without a completion transition before stall_err sets
- CNT_W, 16, width of tokens_sent

Ports:
- clk  input  1  system clock
- init  input  1  asynchronous active-high reset
- req_valid  input  NREQ  requester i has a value
- req_data  input  2*NREQ  value of requester i, bits [2i+1:2i]
- req_ready  output  NREQ  one-hot grant; a transfer occurs on a clk edge with valid&ready
- rail_out  output  4  four-rail wavefront to the first pipeline stage; driven directly from flops
- comp_in  input  1  completion from the first stage, asynchronous; 1 = stage holds DATA, 0 = stage holds NULL
- grant_id  output  $clog2(NREQ)  index of the last accepted requester
- tokens_sent  output  CNT_W  count of DATA wavefronts acknowledged
- stall_err  output  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, init=1):
  - rail_out=0000 (NULL), req_ready=0, grant_id=0, tokens_sent=0, stall_err=0.
  - Synchronizer flops cleared; state=WAIT_NULL; round-robin pointer=0.
  - Reset mid-wavefront forces NULL immediately. This is legal.
- comp_s is comp_in after SYNC_STAGES flops. All decisions use comp_s only.
- FSM states:
  - WAIT_NULL: rail_out=0000. When comp_s==0, go to ARB. The timeout counter runs here.
  - ARB: rail_out=0000. req_ready is asserted combinationally for the single round-robin winner among asserted req_valid.
    - Search starts at pointer and proceeds upward with wrap.
    - No valid requester: stay in ARB, req_ready=0, no timeout counting.
    - On the transfer edge: rail_out <= onehot(req_data[winner]) (value v sets rail v), grant_id <= winner, pointer <= winner+1 mod NREQ, go to WAIT_DATA.
  - WAIT_DATA: hold the rail_out DATA pattern. When comp_s==1: tokens_sent += 1 (wraps at 2^CNT_W), rail_out <= 0000, go to WAIT_NULL. The timeout counter runs here.
- Latency:
  - Transfer edge to DATA on rail_out: 0 cycles (same edge).
  - comp_in rise to rails NULL: SYNC_STAGES+1 edges.
  - Minimum cycle per token: ARB + 2*(SYNC_STAGES+1) edges plus pipeline delay.
- Rail invariants:
  - rail_out is either 0000 or exactly one-hot.
  - Never DATA->DATA. Every DATA is bracketed by NULL.
  - Each rail bit changes at most once per clock.
- req_ready never asserts outside ARB. At most one bit is set. It is dropped the cycle after the transfer.
- Simultaneous requests: only the winner is granted. Losers keep valid and are served in rotation. A requester dropping valid before grant is legal.
- Watchdog:
  - Counter clears on every state entry.
  - Counts in WAIT_NULL/WAIT_DATA. At count==TIMEOUT, stall_err <= 1.
  - stall_err is sticky until init. The FSM keeps waiting; no recovery action.
- comp_s already 1 on entering WAIT_NULL (slow pipeline): wait; no new DATA until comp_s==0.
- comp_s glitches are filtered only by the synchronizer. The pipeline must hold completion monotonic per phase.

Decomposition:
- Package ncl4_pkg:
  - state enum {WAIT_NULL, ARB, WAIT_DATA}
  - NULL4 = 4'b0000
  - function onehot4(2-bit) -> 4-bit rail pattern
  - function is_valid4(4-bit) returning true for NULL or one-hot
- Sub-module ncl_sync: SYNC_STAGES flop chain with async reset on init, reused for other clocked/NCL boundaries.
- Round-robin arbitration stays inline (about 30 lines).

Test Plan:
- Reset, then one token. Release init with NREQ=4; req_valid=0001, req_data[1:0]=2'd2; pipeline model acks after 5 cycles.
  - req_ready=0001 for one cycle; rail_out=0100, then 0000 after comp rise.
  - tokens_sent=1, grant_id=0.
- Round-robin fairness. req_valid=1111 held, data per requester i = i.
  - Grant order 0,1,2,3,0.
  - rail_out DATA sequence 0001,0010,0100,1000,0001, each separated by 0000.
- Contention with dropout. req_valid=0110; requester 2 drops valid before its turn.
  - Grants go 1,1,1; requester 2 is never granted while invalid.
- Stall watchdog. Pipeline model never raises comp after a DATA issue.
  - stall_err=1 exactly TIMEOUT cycles after entering WAIT_DATA.
  - rail_out holds DATA; req_ready stays 0.
- Reset mid-operation. Assert init while rail_out=1000, asynchronously between clk edges.
  - rail_out=0000 and tokens_sent=0 before the next edge.
  - After release, the first grant goes to requester 0.
- Counter wrap. Run with CNT_W=4 for 17 tokens.
  - tokens_sent=1.
  - Property check throughout: rail_out is 0000 or one-hot, never DATA->DATA.

Source files
------------

// File: rtl/ncl4_pkg.sv
// Shared definitions for the clocked NCL four-rail injection front end.
//   state_t    : controller states
//   NULL4      : the all-zero (NULL) four-rail spacer
//   onehot4    : 2-bit value -> four-rail DATA pattern (value v raises rail v)
//   is_valid4  : true when a rail pattern is NULL or exactly one-hot
package ncl4_pkg;

  typedef enum logic [1:0] {
    WAIT_NULL = 2'd0,
    ARB       = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  localparam logic [3:0] NULL4 = 4'b0000;

  function automatic logic [3:0] onehot4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  function automatic logic is_valid4(input logic [3:0] r);
    return (r & (r - 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-flop synchronizer for bringing an asynchronous NCL completion (or any
// other level signal) into the clk domain.
//   clk  : sampling clock
//   init : asynchronous active-high clear of every stage
//   d    : asynchronous input
//   q    : synchronized output, STAGES edges behind d
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic init,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge init) begin
    if (init) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ncl4_inject_arbiter.sv
// Round-robin front end that feeds one four-rail NCL pipeline from NREQ
// synchronous requesters. Each accepted 2-bit value becomes a one-hot DATA
// wavefront; the rails return to NULL once the first stage reports DATA
// complete, and the next value is only accepted once it reports NULL.
//   clk         : system clock
//   init        : asynchronous active-high reset
//   req_valid   : per-requester valid
//   req_data    : per-requester 2-bit value, requester i at [2i+1:2i]
//   req_ready   : one-hot grant, transfer on valid&ready at a clk edge
//   rail_out    : registered four-rail wavefront into the pipeline
//   comp_in     : asynchronous completion from the first stage (1 = DATA)
//   grant_id    : index of the last accepted requester
//   tokens_sent : count of acknowledged DATA wavefronts (wraps)
//   stall_err   : sticky watchdog flag
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_NULL | rails NULL, waiting for stage to report NULL (watchdog runs)
// ARB       | rails NULL, granting the round-robin winner if any is valid
// WAIT_DATA | rails hold DATA, waiting for stage to report DATA (watchdog)
module ncl4_inject_arbiter
  import ncl4_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    init,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [3:0]              rail_out,
  input  logic                    comp_in,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [CNT_W-1:0]        tokens_sent,
  output logic                    stall_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_t         state;
  logic           comp_s;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic [WDW-1:0] wd;
  int             idx;

  ncl_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .init (init),
    .d    (comp_in),
    .q    (comp_s)
  );

  // Round-robin: first valid requester at or above ptr, wrapping around.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ARB && found) req_ready[winner] = 1'b1;
  end

  // Watchdog is a down-counter reloaded on every state change; the edge that
  // sees it at 1 is exactly TIMEOUT edges after entry, and it then parks at 0.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state       <= WAIT_NULL;
      rail_out    <= NULL4;
      grant_id    <= '0;
      ptr         <= '0;
      tokens_sent <= '0;
      stall_err   <= 1'b0;
      wd          <= WD_LOAD;
    end else begin
      case (state)
        WAIT_NULL: begin
          if (!comp_s) begin
            state <= ARB;
            wd    <= WD_LOAD;
          end else begin
            if (wd == WDW'(1)) stall_err <= 1'b1;
            if (wd != '0)      wd <= wd - 1'b1;
          end
        end
        ARB: begin
          if (found) begin
            rail_out <= onehot4(req_data[{winner, 1'b0} +: 2]);
            grant_id <= winner;
            ptr      <= (winner == LAST_ID) ? '0 : winner + 1'b1;
            state    <= WAIT_DATA;
            wd       <= WD_LOAD;
          end
        end
        WAIT_DATA: begin
          if (comp_s) begin
            tokens_sent <= tokens_sent + 1'b1;
            rail_out    <= NULL4;
            state       <= WAIT_NULL;
            wd          <= WD_LOAD;
          end else begin
            if (wd == WDW'(1)) stall_err <= 1'b1;
            if (wd != '0)      wd <= wd - 1'b1;
          end
        end
        default: begin
          state    <= WAIT_NULL;
          rail_out <= NULL4;
          wd       <= WD_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ncl4_inject_arbiter.sv
module tb_ncl4_inject_arbiter;

  localparam int NREQ    = 4;
  localparam int SYNC    = 2;
  localparam int TMO     = 40;
  localparam int CW      = 4;
  localparam int ACK_DLY = 5;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic [3:0] req_valid = '0;
  logic [7:0] req_data = '0;
  logic [3:0] req_ready;
  logic [3:0] rail_out;
  logic       comp_in = 1'b0;
  logic [1:0] grant_id;
  logic [3:0] tokens_sent;
  logic       stall_err;

  int tests = 0;
  int fails = 0;
  bit pipe_en = 1'b1;

  always #5 clk = ~clk;

  ncl4_inject_arbiter #(
    .NREQ(NREQ), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .init(init), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rail_out(rail_out), .comp_in(comp_in),
    .grant_id(grant_id), .tokens_sent(tokens_sent), .stall_err(stall_err)
  );

  typedef struct {
    logic [3:0] valid;
    logic [7:0] data;
    logic [1:0] grant;
    logic [3:0] rail;
    logic [3:0] tokens;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Pipeline model: the first stage follows the rails ACK_DLY cycles later.
  initial begin
    int   cnt;
    logic target;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (init) begin
        comp_in = 1'b0;
        cnt     = 0;
      end else if (pipe_en) begin
        target = (rail_out != 4'b0000);
        if (comp_in != target) begin
          cnt++;
          if (cnt >= ACK_DLY) begin
            comp_in = target;
            cnt     = 0;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Rail and grant invariants, checked every cycle.
  logic [3:0] prev_rail = '0;
  always @(negedge clk) begin
    if (init) begin
      prev_rail = '0;
    end else begin
      if ((rail_out & (rail_out - 4'd1)) != 4'd0) begin
        fails++;
        $display("FAIL rail_onehot: rail_out=%b, required NULL or one-hot", rail_out);
      end
      if (prev_rail != 4'd0 && rail_out != 4'd0 && rail_out != prev_rail) begin
        fails++;
        $display("FAIL data_to_data: rail_out %b -> %b, required NULL between", prev_rail, rail_out);
      end
      if (req_ready != 4'd0 && (rail_out != 4'd0 || (req_ready & (req_ready - 4'd1)) != 4'd0)) begin
        fails++;
        $display("FAIL ready_ctx: req_ready=%b rail_out=%b, required one-hot grant only with NULL rails",
                 req_ready, rail_out);
      end
      prev_rail = rail_out;
    end
  end

  task automatic do_reset();
    init = 1'b1;
    repeat (3) @(negedge clk);
    init = 1'b0;
  endtask

  // One complete token: grant, DATA on rails, ack, return to NULL.
  task automatic do_token(input logic [3:0] v, input logic [7:0] d, input logic [1:0] g,
                          input logic [3:0] rail, input logic [3:0] tok);
    bit ok;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (req_ready != 4'd0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL grant_timeout: req_ready=%b, required %b", req_ready, 4'b0001 << g);
      return;
    end
    check("req_ready", req_ready, 4'b0001 << g);
    @(posedge clk);
    #1;
    check("rail_data", rail_out, rail);
    check("grant_id", grant_id, g);
    check("ready_drop", req_ready, 4'd0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rail_out == 4'd0) ok = 1'b1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL null_timeout: rail_out=%b, required 0000", rail_out);
      return;
    end
    check("rail_null", rail_out, 4'd0);
    check("tokens_sent", tokens_sent, tok);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{4'b1111, 8'hE4, 2'd0, 4'b0001, 4'd1};
    vecs[1] = '{4'b1111, 8'hE4, 2'd1, 4'b0010, 4'd2};
    vecs[2] = '{4'b1111, 8'hE4, 2'd2, 4'b0100, 4'd3};
    vecs[3] = '{4'b1111, 8'hE4, 2'd3, 4'b1000, 4'd4};
    vecs[4] = '{4'b1111, 8'hE4, 2'd0, 4'b0001, 4'd5};
    vecs[5] = '{4'b0110, 8'hE4, 2'd1, 4'b0010, 4'd6};
    vecs[6] = '{4'b0010, 8'hE4, 2'd1, 4'b0010, 4'd7};
    vecs[7] = '{4'b0010, 8'hE4, 2'd1, 4'b0010, 4'd8};

    // Reset values, then a single token.
    init = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rail", rail_out, 4'd0);
    check("rst_ready", req_ready, 4'd0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_tokens", tokens_sent, 4'd0);
    check("rst_stall", stall_err, 1'b0);
    init = 1'b0;
    do_token(4'b0001, 8'h02, 2'd0, 4'b0100, 4'd1);

    // Round-robin fairness and contention with dropout.
    do_reset();
    for (int i = 0; i < 8; i++)
      do_token(vecs[i].valid, vecs[i].data, vecs[i].grant, vecs[i].rail, vecs[i].tokens);

    // Watchdog: pipeline never acknowledges the next DATA.
    @(negedge clk);
    req_valid = 4'b0001;
    req_data  = 8'h03;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (req_ready != 4'd0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL stall_grant_timeout: req_ready=%b, required 0001", req_ready);
    end
    pipe_en = 1'b0;
    check("stall_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("stall_rail", rail_out, 4'b1000);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("stall_early", stall_err, 1'b0);
    @(posedge clk);
    #1;
    check("stall_set", stall_err, 1'b1);
    check("stall_hold_rail", rail_out, 4'b1000);
    check("stall_no_ready", req_ready, 4'd0);
    check("stall_tokens", tokens_sent, 4'd8);

    // Asynchronous reset in the middle of a DATA wavefront.
    #3;
    init = 1'b1;
    #1;
    check("midrst_rail", rail_out, 4'd0);
    check("midrst_tokens", tokens_sent, 4'd0);
    check("midrst_stall", stall_err, 1'b0);
    check("midrst_ready", req_ready, 4'd0);
    repeat (2) @(negedge clk);
    init = 1'b0;
    pipe_en = 1'b1;

    // Counter wrap at 2^CW; first grant after reset is requester 0.
    for (int i = 0; i < 17; i++)
      do_token(4'b1111, 8'hE4, 2'(i % 4), 4'b0001 << (i % 4), 4'((i + 1) % 16));
    check("wrap_tokens", tokens_sent, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
